// File: rtl/fp_pkg.sv
// Shared types, constants and the round/pack helper for the binary32 add/sub/div unit.
package fp_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned ADD_LAT  = 3;
  localparam int unsigned DIV_LAT  = 28;
  localparam int unsigned SIG_W    = MANT_W + 1;      // significand with hidden bit
  localparam int unsigned ALN_W    = SIG_W + 3;       // significand + guard/round/sticky
  localparam int unsigned QUO_W    = DIV_LAT - 2;     // quotient bits: 24 + guard + round
  localparam int unsigned WIDE_W   = SIG_W + ALN_W - 1;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;

  // Round-to-nearest-even, handle carry-out, then saturate to inf or flush to signed zero.
  function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                             input logic [SIG_W-1:0] m, input logic g,
                                             input logic r, input logic st);
    logic [SIG_W:0]    mr;
    logic signed [9:0] er;
    logic [31:0]       res;
    mr = {1'b0, m} + (SIG_W+1)'(g & (r | st | m[0]));
    er = e;
    if (mr[SIG_W]) begin
      mr = mr >> 1;
      er = e + 10'sd1;
    end
    if (er >= 10'sd255)    res = {s, FP_PINF[30:0]};
    else if (er <= 10'sd0) res = {s, 31'd0};
    else                   res = {s, er[EXP_W-1:0], mr[MANT_W-1:0]};
    return res;
  endfunction

endpackage

// File: rtl/fp_mant_div.sv
// Restoring significand divider: one quotient bit per cycle, num pre-scaled so quotient is in [1,2).
module fp_mant_div
  import fp_pkg::*;
(
  input  logic             c,
  input  logic             rst,
  input  logic             start,
  input  logic [SIG_W:0]   num,
  input  logic [SIG_W-1:0] den,
  output logic [SIG_W-1:0] quo,
  output logic             guard_bit,
  output logic             round_bit,
  output logic             sticky_bit,
  output logic             done
);

  localparam int unsigned CNT_W = 5;

  logic [SIG_W:0]   rem;
  logic [SIG_W-1:0] den_r;
  logic [QUO_W-1:0] qb;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [SIG_W+1:0] diff_c;
  logic             ge_c;
  logic [SIG_W:0]   rem_sel_c;

  // Trial subtraction; keep the difference when it does not go negative
  always_comb begin
    diff_c    = {1'b0, rem} - {2'b00, den_r};
    ge_c      = ~diff_c[SIG_W+1];
    rem_sel_c = ge_c ? diff_c[SIG_W:0] : rem;
  end

  // Iteration state: load on start, shift one quotient bit in per cycle
  always_ff @(posedge c) begin
    if (rst) begin
      rem        <= '0;
      den_r      <= '0;
      qb         <= '0;
      cnt        <= '0;
      run        <= 1'b0;
      done       <= 1'b0;
      sticky_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem        <= num;
        den_r      <= den;
        qb         <= '0;
        cnt        <= '0;
        run        <= 1'b1;
        sticky_bit <= 1'b0;
      end else if (run) begin
        qb  <= {qb[QUO_W-2:0], ge_c};
        rem <= {rem_sel_c[SIG_W-1:0], 1'b0};
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(QUO_W - 1)) begin
          run        <= 1'b0;
          done       <= 1'b1;
          sticky_bit <= |rem_sel_c;
        end
      end
    end
  end

  assign quo       = qb[QUO_W-1:2];
  assign guard_bit = qb[1];
  assign round_bit = qb[0];

endmodule

// File: rtl/fp_addsub_div.sv
// Multi-cycle binary32 add/sub (3-stage pipe) and divide (iterative) with start/done handshake.
module fp_addsub_div
  import fp_pkg::*;
(
  input  logic        c,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic        done,
  output logic        busy
);

  state_e            state, state_nx;
  logic              accept_c, finish_c;
  fp32_t             a_r, b_r;
  logic [1:0]        op_r, cnt;
  logic              div_go;
  // operand classification
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sb_eff;
  // stage 1
  logic [30:0]       mag_a, mag_b;
  logic              swap_c, sx_c, sy_c, spec1_c;
  logic [EXP_W-1:0]  ex_c, ey_c, d_c;
  logic [SIG_W-1:0]  ma_c, mb_c, mx_c, my_c;
  logic [5:0]        sh_c;
  logic [WIDE_W-1:0] wide_c;
  logic [31:0]       val1_c;
  logic              s1_spec, s1_sign, s1_sub;
  logic [31:0]       s1_val;
  logic [EXP_W-1:0]  s1_exp;
  logic [ALN_W-1:0]  s1_mx, s1_my;
  // stage 2
  logic [ALN_W:0]    sum_c;
  logic [4:0]        lz_c;
  logic [ALN_W-1:0]  norm_c;
  logic signed [9:0] e2_c;
  logic              s2_spec, s2_sign;
  logic [31:0]       s2_val;
  logic signed [9:0] s2_exp;
  logic [ALN_W-1:0]  s2_norm;
  // divide
  logic              div_lt_c;
  logic [SIG_W:0]    num_c;
  logic [SIG_W-1:0]  den_c, mq;
  logic signed [9:0] de_c;
  logic              mg, mrb, ms, mdiv_done;
  logic [31:0]       add_res_c, div_res_c;

  // Operand classification; subnormals count as zero
  always_comb begin
    a_zero = (a_r.exp == '0);
    b_zero = (b_r.exp == '0);
    a_inf  = (a_r.exp == '1) && (a_r.frac == '0);
    b_inf  = (b_r.exp == '1) && (b_r.frac == '0);
    a_nan  = (a_r.exp == '1) && (a_r.frac != '0);
    b_nan  = (b_r.exp == '1) && (b_r.frac != '0);
    sb_eff = b_r.sign ^ (op_r == OP_SUB);
    ma_c   = a_zero ? '0 : {1'b1, a_r.frac};
    mb_c   = b_zero ? '0 : {1'b1, b_r.frac};
  end

  // Stage 1: order by magnitude, align the smaller significand with sticky collection
  always_comb begin
    mag_a  = a_zero ? '0 : {a_r.exp, a_r.frac};
    mag_b  = b_zero ? '0 : {b_r.exp, b_r.frac};
    swap_c = (mag_b > mag_a);
    sx_c   = swap_c ? sb_eff   : a_r.sign;
    sy_c   = swap_c ? a_r.sign : sb_eff;
    ex_c   = swap_c ? b_r.exp  : a_r.exp;
    ey_c   = swap_c ? a_r.exp  : b_r.exp;
    mx_c   = swap_c ? mb_c     : ma_c;
    my_c   = swap_c ? ma_c     : mb_c;
    d_c    = ex_c - ey_c;
    sh_c   = (d_c > EXP_W'(WIDE_W - 1)) ? 6'(WIDE_W - 1) : 6'(d_c);
    wide_c = {my_c, {(ALN_W-1){1'b0}}} >> sh_c;
    spec1_c = 1'b1;
    if (a_nan || b_nan)         val1_c = FP_QNAN;
    else if (a_inf && b_inf)    val1_c = (a_r.sign != sb_eff) ? FP_QNAN : {a_r.sign, FP_PINF[30:0]};
    else if (a_inf)             val1_c = {a_r.sign, FP_PINF[30:0]};
    else if (b_inf)             val1_c = {sb_eff, FP_PINF[30:0]};
    else if (a_zero && b_zero)  val1_c = {a_r.sign & sb_eff, 31'd0};
    else begin
      spec1_c = 1'b0;
      val1_c  = 32'd0;
    end
  end

  // Stage 2: magnitude add/subtract, leading-zero count, normalize
  always_comb begin
    sum_c = s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});
    lz_c  = 5'd0;
    for (int i = 0; i < int'(ALN_W); i++) begin
      if (sum_c[i]) lz_c = 5'(int'(ALN_W) - 1 - i);
    end
    if (sum_c[ALN_W]) begin
      norm_c = {sum_c[ALN_W:2], sum_c[1] | sum_c[0]};
      e2_c   = 10'(s1_exp) + 10'sd1;
    end else begin
      norm_c = sum_c[ALN_W-1:0] << lz_c;
      e2_c   = 10'(s1_exp) - 10'(lz_c);
    end
  end

  // Add/sub pipeline registers
  always_ff @(posedge c) begin
    if (rst) begin
      s1_spec <= 1'b0; s1_val <= '0; s1_sign <= 1'b0; s1_sub <= 1'b0;
      s1_exp  <= '0;   s1_mx  <= '0; s1_my   <= '0;
      s2_spec <= 1'b0; s2_val <= '0; s2_sign <= 1'b0; s2_exp <= '0; s2_norm <= '0;
    end else begin
      s1_spec <= spec1_c;
      s1_val  <= val1_c;
      s1_sign <= sx_c;
      s1_sub  <= sx_c ^ sy_c;
      s1_exp  <= ex_c;
      s1_mx   <= {mx_c, 3'b000};
      s1_my   <= {wide_c[WIDE_W-1:SIG_W], |wide_c[SIG_W-1:0]};
      s2_spec <= s1_spec | (sum_c == '0);
      s2_val  <= s1_spec ? s1_val : 32'd0;
      s2_sign <= s1_sign;
      s2_exp  <= e2_c;
      s2_norm <= norm_c;
    end
  end

  // Stage 3 result and divide operand prep / result pack
  always_comb begin
    add_res_c = s2_spec ? s2_val
              : round_pack(s2_sign, s2_exp, s2_norm[ALN_W-1:3], s2_norm[2], s2_norm[1], s2_norm[0]);
    div_lt_c  = ({1'b1, a_r.frac} < {1'b1, b_r.frac});
    num_c     = div_lt_c ? {1'b1, a_r.frac, 1'b0} : {2'b01, a_r.frac};
    den_c     = {1'b1, b_r.frac};
    de_c      = 10'(a_r.exp) - 10'(b_r.exp) + 10'(EXP_BIAS) - 10'(div_lt_c);
    if (a_nan || b_nan)                         div_res_c = FP_QNAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) div_res_c = FP_QNAN;
    else if (a_inf || b_zero)                   div_res_c = {a_r.sign ^ b_r.sign, FP_PINF[30:0]};
    else if (b_inf || a_zero)                   div_res_c = {a_r.sign ^ b_r.sign, 31'd0};
    else div_res_c = round_pack(a_r.sign ^ b_r.sign, de_c, mq, mg, mrb, ms);
  end

  fp_mant_div u_mdiv (
    .c          (c),
    .rst        (rst),
    .start      (div_go),
    .num        (num_c),
    .den        (den_c),
    .quo        (mq),
    .guard_bit  (mg),
    .round_bit  (mrb),
    .sticky_bit (ms),
    .done       (mdiv_done)
  );

  // FSM state register
  always_ff @(posedge c) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next state: accept when idle, finish on fixed latency or divider done
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept_c = 1'b1;
        state_nx = (op == OP_DIV) ? S_DIV : S_ADD;
      end
      S_ADD: if (cnt == 2'(ADD_LAT - 1)) begin
        finish_c = 1'b1;
        state_nx = S_IDLE;
      end
      S_DIV: if (mdiv_done) begin
        finish_c = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, handshake outputs and result register
  always_ff @(posedge c) begin
    if (rst) begin
      q <= '0; done <= 1'b0; busy <= 1'b0; cnt <= '0; div_go <= 1'b0;
      a_r <= '0; b_r <= '0; op_r <= '0;
    end else begin
      done   <= finish_c;
      div_go <= accept_c & (op == OP_DIV);
      cnt    <= accept_c ? 2'd0 : cnt + 2'd1;
      if (accept_c) begin
        a_r  <= a;
        b_r  <= b;
        op_r <= op;
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (finish_c) q <= (state == S_DIV) ? div_res_c : add_res_c;
    end
  end

endmodule

// File: tb/tb_fp_addsub_div.sv
// Scoreboard bench for fp_addsub_div: expected results queued at issue, compared on done.
module tb_fp_addsub_div;
  import fp_pkg::*;

  logic        c = 1'b0;
  logic        rst, start;
  logic [1:0]  op;
  logic [31:0] a, b, q;
  logic        done, busy;

  int          cyc, n_cmp, n_err;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          k_q[$];
  string       tag_q[$];
  logic [31:0] last_q, mon_e;
  int          mon_l, mon_k;
  string       mon_t;

  logic [1:0]  v_op[16];
  logic [31:0] v_a[16], v_b[16], v_w[16];

  fp_addsub_div dut (
    .c(c), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .q(q), .done(done), .busy(busy)
  );

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive a one-cycle start and queue the expected result and latency
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] want, input string tag);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge c);
    #1;
    start = 1'b0;
    exp_q.push_back(want);
    lat_q.push_back((o == OP_DIV) ? int'(DIV_LAT) : int'(ADD_LAT));
    k_q.push_back(cyc);
    tag_q.push_back(tag);
  endtask

  // Wait for done with busy checked every cycle; optionally pulse start while busy
  task automatic wait_done(input string tag, input int poke);
    for (int i = 0; i < 40; i++) begin
      @(negedge c);
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) begin
        start = 1'b0;
        return;
      end
      start = (i == poke);
      if (i == poke) begin
        op = OP_ADD; a = 32'h3F80_0000; b = 32'h3F80_0000;
      end
    end
    check_eq({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge c);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  // Result monitor: pop on done, otherwise q must hold
  always @(negedge c) begin
    if (rst) begin
      last_q = 32'd0;
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          mon_k = k_q.pop_front();
          mon_t = tag_q.pop_front();
          check_eq({mon_t, "_q"}, q, mon_e);
          check_eq({mon_t, "_lat"}, 32'(cyc - mon_k), 32'(mon_l));
        end
      end else begin
        check_eq("q_hold", q, last_q);
      end
      last_q = q;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    v_op = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00,
             2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
    v_a  = '{32'h3F800000, 32'h3F800000, 32'h3E4CCCCD, 32'h3F800000,
             32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F7FFFFF,
             32'h00000001, 32'h80000000, 32'h3F800000, 32'h40C00000,
             32'hC0000000, 32'h7FC00000, 32'h7F800000, 32'h3F800000};
    v_b  = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3DCCCCCD,
             32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F7FFFFF,
             32'h00000000, 32'h80000000, 32'h40000000, 32'h40400000,
             32'h7F800000, 32'h3F800000, 32'h7F800000, 32'h40000000};
    v_w  = '{32'h40400000, 32'h00000000, 32'hBF4CCCCD, 32'h41200000,
             32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
             32'h00000000, 32'h80000000, 32'h40400000, 32'h40000000,
             32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'hBF800000};

    rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
    repeat (3) @(negedge c);
    check_eq("rst_q", q, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge c);

    // Directed vectors; every divide also gets a start pulse while busy
    for (int i = 0; i < 16; i++) begin
      issue(v_op[i], v_a[i], v_b[i], v_w[i], $sformatf("v%0d", i));
      wait_done($sformatf("v%0d", i), (v_op[i] == OP_DIV) ? 5 : -1);
      idle_check($sformatf("v%0d", i));
    end

    // Reset in the middle of a divide aborts it
    issue(OP_DIV, 32'h3F800000, 32'h3DCCCCCD, 32'h41200000, "abort");
    repeat (9) @(negedge c);
    rst = 1'b1;
    @(negedge c);
    exp_q.delete(); lat_q.delete(); k_q.delete(); tag_q.delete();
    check_eq("abort_q", q, 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (35) @(negedge c);
    check_eq("abort_quiet_busy", 32'(busy), 32'd0);
    issue(OP_ADD, 32'h40000000, 32'h40000000, 32'h40800000, "post_rst");
    wait_done("post_rst", -1);
    idle_check("post_rst");

    // Back-to-back: add issued on the divide's done cycle
    issue(OP_DIV, 32'h40C00000, 32'h40400000, 32'h40000000, "b2b_div");
    wait_done("b2b_div", -1);
    issue(OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, "b2b_add");
    wait_done("b2b_add", -1);
    idle_check("b2b_add");

    repeat (5) @(negedge c);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
